// File: rtl/rf_port_sched_pkg.sv
// Shared types for the register-file port scheduler: the read FSM state
// encoding and the writeback source identifiers used by the round-robin arbiter.
package rf_port_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD1  = 2'd1,
        S_RD2  = 2'd2,
        S_RESP = 2'd3
    } rf_sched_state_e;

    typedef enum logic {
        WB_EXU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    function automatic wb_src_e rr_flip(input wb_src_e src);
        return (src == WB_EXU) ? WB_LSU : WB_EXU;
    endfunction

endpackage

// File: rtl/rf_port_sched_wb_rr_arb.sv
// Two-way round-robin arbiter placing EXU/LSU writebacks onto the single
// regfile write port; grants are combinational, writes to x0 are swallowed.
module rf_wb_rr_arb
    import rf_port_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_addr,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata
);

    wb_src_e rr_ptr_r;
    logic    contended_s;
    logic    exu_gnt_s;
    logic    lsu_gnt_s;

    // Grant selection and write-port mux
    always_comb begin
        contended_s = exu_valid && lsu_valid;
        exu_gnt_s   = 1'b0;
        lsu_gnt_s   = 1'b0;
        waddr       = {ADDR_WIDTH{1'b0}};
        wdata       = {DATA_WIDTH{1'b0}};
        if (contended_s) begin
            exu_gnt_s = (rr_ptr_r == WB_EXU);
            lsu_gnt_s = (rr_ptr_r == WB_LSU);
        end else begin
            exu_gnt_s = exu_valid;
            lsu_gnt_s = lsu_valid;
        end
        if (exu_gnt_s) begin
            waddr = exu_addr;
            wdata = exu_data;
        end else if (lsu_gnt_s) begin
            waddr = lsu_addr;
            wdata = lsu_data;
        end else begin
            waddr = {ADDR_WIDTH{1'b0}};
            wdata = {DATA_WIDTH{1'b0}};
        end
    end

    assign exu_ready = exu_gnt_s;
    assign lsu_ready = lsu_gnt_s;
    assign wen       = (exu_gnt_s || lsu_gnt_s) && (waddr != {ADDR_WIDTH{1'b0}});

    // Priority pointer only moves when both sources competed
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= WB_EXU;
        end else if (contended_s) begin
            rr_ptr_r <= rr_flip(rr_ptr_r);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/rf_port_sched.sv
// Scheduler in front of a 1R/1W regfile: serialises rs1/rs2 reads over the
// single read port (with write bypass) and arbitrates EXU/LSU writebacks.
module rf_port_sched
    import rf_port_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rd_rsp_valid,
    input  logic                  rd_rsp_ready,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  exu_wb_valid,
    output logic                  exu_wb_ready,
    input  logic [ADDR_WIDTH-1:0] exu_wb_addr,
    input  logic [DATA_WIDTH-1:0] exu_wb_data,
    input  logic                  lsu_wb_valid,
    output logic                  lsu_wb_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_wb_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wb_data,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_wen
);

    rf_sched_state_e       state_r;
    rf_sched_state_e       state_nxt_s;
    logic [ADDR_WIDTH-1:0] rs1_addr_r;
    logic [ADDR_WIDTH-1:0] rs2_addr_r;
    logic [DATA_WIDTH-1:0] rs1_data_r;
    logic [DATA_WIDTH-1:0] rs2_data_r;
    logic [ADDR_WIDTH-1:0] raddr_s;
    logic [DATA_WIDTH-1:0] cap_s;
    logic                  same_src_s;

    rf_wb_rr_arb #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wb_arb (
        .clk      (clk),
        .rst      (rst),
        .exu_valid(exu_wb_valid),
        .exu_ready(exu_wb_ready),
        .exu_addr (exu_wb_addr),
        .exu_data (exu_wb_data),
        .lsu_valid(lsu_wb_valid),
        .lsu_ready(lsu_wb_ready),
        .lsu_addr (lsu_wb_addr),
        .lsu_data (lsu_wb_data),
        .wen      (rf_wen),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata)
    );

    assign same_src_s = (rs1_addr_r == rs2_addr_r);

    // Read FSM next state and read-port address
    always_comb begin
        state_nxt_s = state_r;
        raddr_s     = {ADDR_WIDTH{1'b0}};
        case (state_r)
            S_IDLE: begin
                if (rd_req_valid) state_nxt_s = S_RD1;
                else              state_nxt_s = S_IDLE;
            end
            S_RD1: begin
                raddr_s     = rs1_addr_r;
                state_nxt_s = same_src_s ? S_RESP : S_RD2;
            end
            S_RD2: begin
                raddr_s     = rs2_addr_r;
                state_nxt_s = S_RESP;
            end
            S_RESP: begin
                if (rd_rsp_ready) state_nxt_s = S_IDLE;
                else              state_nxt_s = S_RESP;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Captured value: x0 reads zero, a same-cycle write wins over the stale regfile read
    always_comb begin
        cap_s = rf_rdata;
        if (raddr_s == {ADDR_WIDTH{1'b0}}) begin
            cap_s = {DATA_WIDTH{1'b0}};
        end else if (rf_wen && (rf_waddr == raddr_s)) begin
            cap_s = rf_wdata;
        end else begin
            cap_s = rf_rdata;
        end
    end

    // State, latched source indices and operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            rs1_addr_r <= {ADDR_WIDTH{1'b0}};
            rs2_addr_r <= {ADDR_WIDTH{1'b0}};
            rs1_data_r <= {DATA_WIDTH{1'b0}};
            rs2_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                S_IDLE: begin
                    if (rd_req_valid) begin
                        rs1_addr_r <= rs1_addr;
                        rs2_addr_r <= rs2_addr;
                    end
                end
                S_RD1: begin
                    rs1_data_r <= cap_s;
                    if (same_src_s) rs2_data_r <= cap_s;
                end
                S_RD2: begin
                    rs2_data_r <= cap_s;
                end
                default: begin
                    rs1_data_r <= rs1_data_r;
                end
            endcase
        end
    end

    assign rd_req_ready = (state_r == S_IDLE);
    assign rd_rsp_valid = (state_r == S_RESP);
    assign rs1_data     = rs1_data_r;
    assign rs2_data     = rs2_data_r;
    assign rf_raddr     = raddr_s;

endmodule

// File: tb/tb_rf_port_sched.sv
// Directed bench for rf_port_sched with a behavioural 32x32 regfile
// (combinational read of the old value, write on posedge).
module tb_rf_port_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        exu_wb_valid;
    logic        exu_wb_ready;
    logic [4:0]  exu_wb_addr;
    logic [31:0] exu_wb_data;
    logic        lsu_wb_valid;
    logic        lsu_wb_ready;
    logic [4:0]  lsu_wb_addr;
    logic [31:0] lsu_wb_data;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wen;

    logic [31:0] mem [32];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_port_sched #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .exu_wb_valid(exu_wb_valid), .exu_wb_ready(exu_wb_ready),
        .exu_wb_addr(exu_wb_addr), .exu_wb_data(exu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen)
    );

    // Regfile model: cleared on reset, x0 always reads zero
    assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : mem[rf_raddr];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
        end else if (rf_wen) begin
            mem[rf_waddr] <= rf_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exu_write(input logic [4:0] a, input logic [31:0] d);
        exu_wb_valid = 1'b1; exu_wb_addr = a; exu_wb_data = d;
        #1;
        chk("exu_wr_ready", {31'd0, exu_wb_ready}, 32'd1);
        tick();
        exu_wb_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2, input int exp_lat,
                           input logic [31:0] e1, input logic [31:0] e2, input string tag);
        int lat;
        rd_req_valid = 1'b1; rs1_addr = a1; rs2_addr = a2;
        #1;
        chk({tag, "_req_ready"}, {31'd0, rd_req_ready}, 32'd1);
        tick();
        rd_req_valid = 1'b0;
        lat = 1;
        while (!rd_rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rs1"}, rs1_data, e1);
        chk({tag, "_rs2"}, rs2_data, e2);
        rd_rsp_ready = 1'b1;
        tick();
        rd_rsp_ready = 1'b0;
        #1;
        chk({tag, "_rsp_done"}, {31'd0, rd_rsp_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rd_req_valid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0; rd_rsp_ready = 1'b0;
        exu_wb_valid = 1'b0; exu_wb_addr = 5'd0; exu_wb_data = 32'd0;
        lsu_wb_valid = 1'b0; lsu_wb_addr = 5'd0; lsu_wb_data = 32'd0;
        repeat (2) tick();
        chk("rst_req_ready", {31'd0, rd_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
        chk("rst_rs1_data", rs1_data, 32'd0);
        chk("rst_rs2_data", rs2_data, 32'd0);
        chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
        chk("rst_rf_raddr", {27'd0, rf_raddr}, 32'd0);
        rst = 1'b0;
        tick();

        exu_write(5'd5, 32'h11);
        exu_write(5'd6, 32'h22);
        exu_write(5'd7, 32'h33);
        do_read(5'd5, 5'd6, 3, 32'h11, 32'h22, "r5_6");
        do_read(5'd0, 5'd7, 3, 32'h0,  32'h33, "r0_7");
        do_read(5'd7, 5'd7, 2, 32'h33, 32'h33, "r7_7");

        // Bypass: EXU writes x9 in the S_RD1 cycle that reads x9
        rd_req_valid = 1'b1; rs1_addr = 5'd9; rs2_addr = 5'd5;
        tick();
        rd_req_valid = 1'b0;
        exu_wb_valid = 1'b1; exu_wb_addr = 5'd9; exu_wb_data = 32'hABCD;
        #1;
        chk("byp_raddr", {27'd0, rf_raddr}, 32'd9);
        chk("byp_wen", {31'd0, rf_wen}, 32'd1);
        tick();
        exu_wb_valid = 1'b0;
        tick();
        chk("byp_rsp_valid", {31'd0, rd_rsp_valid}, 32'd1);
        chk("byp_rs1", rs1_data, 32'hABCD);
        chk("byp_rs2", rs2_data, 32'h11);
        rd_rsp_ready = 1'b1;
        tick();
        rd_rsp_ready = 1'b0;

        // Contended writers alternate starting with EXU
        exu_wb_valid = 1'b1; exu_wb_addr = 5'd1; exu_wb_data = 32'h101;
        lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd2; lsu_wb_data = 32'h202;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_exu_ready", {31'd0, exu_wb_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_lsu_ready", {31'd0, lsu_wb_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_wen", {31'd0, rf_wen}, 32'd1);
            chk("rr_waddr", {27'd0, rf_waddr}, (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        exu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
        do_read(5'd1, 5'd2, 3, 32'h101, 32'h202, "r1_2");

        // Write to x0 is accepted but suppressed
        lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd0; lsu_wb_data = 32'hFFFF;
        #1;
        chk("x0_lsu_ready", {31'd0, lsu_wb_ready}, 32'd1);
        chk("x0_wen", {31'd0, rf_wen}, 32'd0);
        tick();
        lsu_wb_valid = 1'b0;
        do_read(5'd0, 5'd0, 2, 32'h0, 32'h0, "r0_0");

        // Response held under backpressure; later write must not leak into latched data
        rd_req_valid = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd6;
        tick();
        rd_req_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            exu_wb_valid = (i == 0); exu_wb_addr = 5'd5; exu_wb_data = 32'h55;
            #1;
            chk("hold_rsp_valid", {31'd0, rd_rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'd0, rd_req_ready}, 32'd0);
            chk("hold_rs1", rs1_data, 32'h11);
            chk("hold_rs2", rs2_data, 32'h22);
            tick();
        end
        exu_wb_valid = 1'b0;
        rd_rsp_ready = 1'b1;
        tick();
        rd_rsp_ready = 1'b0;
        do_read(5'd5, 5'd5, 2, 32'h55, 32'h55, "r5_5");

        // One contended grant moves rr_ptr to LSU
        exu_wb_valid = 1'b1; exu_wb_addr = 5'd3; exu_wb_data = 32'h3;
        lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd4; lsu_wb_data = 32'h4;
        #1;
        chk("pre_rst_exu_ready", {31'd0, exu_wb_ready}, 32'd1);
        tick();
        #1;
        chk("pre_rst_lsu_ready", {31'd0, lsu_wb_ready}, 32'd1);
        exu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;

        // Reset while in S_RD2 drops the read and restores EXU priority
        rd_req_valid = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd6;
        tick();
        rd_req_valid = 1'b0;
        tick();
        #1;
        chk("rd2_raddr", {27'd0, rf_raddr}, 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, rd_req_ready}, 32'd1);
        chk("mid_rst_rs1", rs1_data, 32'd0);
        exu_wb_valid = 1'b1; lsu_wb_valid = 1'b1;
        #1;
        chk("mid_rst_exu_ready", {31'd0, exu_wb_ready}, 32'd1);
        chk("mid_rst_lsu_ready", {31'd0, lsu_wb_ready}, 32'd0);
        exu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
        repeat (3) tick();
        chk("mid_rst_no_rsp", {31'd0, rd_rsp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
